// File: rtl/addsub_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   nslice    : number of slices for a given width/slice size
//   idx_width : bit width of the slice index register (minimum 1)
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational SLICE-bit adder used once per clock by serial_addsub.
//   a, b     : slice operands (b already inverted for subtract)
//   cin      : carry into the slice LSB
//   sum      : slice sum
//   cout     : carry out of the slice MSB
//   cin_msb  : carry into the slice MSB, used for signed-overflow detection
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cin_msb
);

  always_comb begin
    {cout, sum} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    cin_msb     = sum[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle two's-complement adder/subtractor, SLICE bits per clock.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_ready high only in IDLE
//   in_a, in_b, in_sub  : operands and operation (0 = A+B, 1 = A-B)
//   out_valid/out_ready : result handshake; out_valid high only in DONE
//   out_result          : A +/- B mod 2^WIDTH
//   out_carry           : carry out of MSB (subtract: 1 = no borrow)
//   out_overflow        : signed overflow
//   out_zero            : out_result == 0
//   dbg_state           : current FSM state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready/valid are pure state decodes with no combinational path
// from the opposite side's valid/ready.
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero,
  output state_t           dbg_state
);

  localparam int NSLICE = nslice(WIDTH, SLICE);
  localparam int IDXW   = idx_width(NSLICE);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  if ((WIDTH % SLICE) != 0 || WIDTH < SLICE) begin : g_bad_params
    $error("serial_addsub: WIDTH must be a non-zero multiple of SLICE");
  end

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [SLICE-1:0]  sl_a, sl_b, sl_sum;
  logic              sl_cout, sl_cin_msb;

  always_comb begin
    sl_a = a_q[int'(idx_q)*SLICE +: SLICE];
    sl_b = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a       (sl_a),
    .b       (sl_b),
    .cin     (carry_q),
    .sum     (sl_sum),
    .cout    (sl_cout),
    .cin_msb (sl_cin_msb)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtract is A + ~B + 1: invert B here, seed carry with in_sub.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          zero_d  = 1'b1;
          ovf_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[int'(idx_q)*SLICE +: SLICE] = sl_sum;
        carry_d = sl_cout;
        if (sl_sum != '0) zero_d = 1'b0;
        if (idx_q == LAST_IDX) begin
          // Signed overflow: carry into MSB differs from carry out of MSB.
          ovf_d   = sl_cin_msb ^ sl_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign out_result   = result_q;
  assign out_carry    = carry_q;
  assign out_overflow = ovf_q;
  assign out_zero     = zero_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;
  import addsub_pkg::*;

  localparam int W = 11;  // {carry, overflow, zero, result[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- DUT 8/4 ----------------
  logic       v8 = 0, r8, s8 = 0, ov8, ordy8 = 0, c8, o8, z8;
  logic [7:0] a8 = 0, b8 = 0, res8;
  state_t     st8;
  serial_addsub #(.WIDTH(8), .SLICE(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
    .in_sub(s8), .out_valid(ov8), .out_ready(ordy8), .out_result(res8),
    .out_carry(c8), .out_overflow(o8), .out_zero(z8), .dbg_state(st8));

  // ---------------- DUT 32/8 ----------------
  logic        v32 = 0, r32, s32 = 0, ov32, ordy32 = 0, c32, o32, z32;
  logic [31:0] a32 = 0, b32 = 0, res32;
  state_t      st32;
  serial_addsub #(.WIDTH(32), .SLICE(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32), .in_a(a32), .in_b(b32),
    .in_sub(s32), .out_valid(ov32), .out_ready(ordy32), .out_result(res32),
    .out_carry(c32), .out_overflow(o32), .out_zero(z32), .dbg_state(st32));

  // ---------------- DUT 8/8 ----------------
  logic       v88 = 0, r88, s88 = 0, ov88, ordy88 = 0, c88, o88, z88;
  logic [7:0] a88 = 0, b88 = 0, res88;
  state_t     st88;
  serial_addsub #(.WIDTH(8), .SLICE(8)) dut88 (
    .clk(clk), .rst_n(rst_n), .in_valid(v88), .in_ready(r88), .in_a(a88), .in_b(b88),
    .in_sub(s88), .out_valid(ov88), .out_ready(ordy88), .out_result(res88),
    .out_carry(c88), .out_overflow(o88), .out_zero(z88), .dbg_state(st88));

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Full transaction on the 8/4 instance: accept, latency, result, handshake.
  task automatic do8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [7:0] res, input logic c, input logic v, input logic z);
    int lat;
    logic [W-1:0] e;
    exp_q.push_back({c, v, z, res});
    check("rdy8_before", r8, 1'b1);
    a8 = a; b8 = b; s8 = sub; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1));
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat8", lat, 2);
    e = exp_q.pop_front();
    check("res8", res8, e[7:0]);
    check("carry8", c8, e[10]);
    check("ovf8", o8, e[9]);
    check("zero8", z8, e[8]);
    check("rdy8_busy", r8, 1'b0);
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("rdy8_after", r8, 1'b1);
    check("valid8_after", ov8, 1'b0);
  endtask

  task automatic do32(input logic [31:0] a, input logic [31:0] b, input logic sub,
                      input logic [31:0] res, input logic c, input logic v, input logic z);
    int lat;
    a32 = a; b32 = b; s32 = sub; v32 = 1'b1;
    @(negedge clk);
    v32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 0;
    while (!ov32 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat32", lat, 4);
    check("res32", res32, res);
    check("carry32", c32, c);
    check("ovf32", o32, v);
    check("zero32", z32, z);
    ordy32 = 1'b1;
    @(negedge clk);
    ordy32 = 1'b0;
    check("rdy32_after", r32, 1'b1);
  endtask

  task automatic do88(input logic [7:0] a, input logic [7:0] b, input logic sub,
                      input logic [7:0] res, input logic c, input logic v, input logic z);
    int lat;
    a88 = a; b88 = b; s88 = sub; v88 = 1'b1;
    @(negedge clk);
    v88 = 1'b0; a88 = 8'($urandom); b88 = 8'($urandom);
    lat = 0;
    while (!ov88 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat88", lat, 1);
    check("res88", res88, res);
    check("carry88", c88, c);
    check("ovf88", o88, v);
    check("zero88", z88, z);
    ordy88 = 1'b1;
    @(negedge clk);
    ordy88 = 1'b0;
    check("rdy88_after", r88, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rdy8", r8, 1'b1);
    check("rst_valid8", ov8, 1'b0);
    check("rst_res8", res8, 8'h00);
    check("rst_flags8", {c8, o8, z8}, 3'b000);
    check("rst_state8", st8, IDLE);
    check("rst_res32", res32, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8/4 directed vectors
    do8(8'd124, 8'd200, 1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
    do8(8'd100, 8'd100, 1'b0, 8'hC8, 1'b0, 1'b1, 1'b0);
    do8(8'h80,  8'h01,  1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    do8(8'd4,   8'd4,   1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    do8(8'd1,   8'd7,   1'b1, 8'hFA, 1'b0, 1'b0, 1'b0);

    // 32/8 and 8/8
    do32(32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do32(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do88(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    do88(8'h05, 8'h09, 1'b1, 8'hFC, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE 5 cycles while pulsing in_valid
    a8 = 8'd10; b8 = 8'd20; s8 = 1'b0; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (2) @(negedge clk);
    check("bp_valid", ov8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("bp_hold_res", res8, 8'd30);
      check("bp_hold_valid", ov8, 1'b1);
      check("bp_hold_rdy", r8, 1'b0);
      check("bp_hold_flags", {c8, o8, z8}, 3'b000);
    end
    v8 = 1'b0;
    ordy8 = 1'b1;
    @(negedge clk);
    ordy8 = 1'b0;
    check("bp_release_rdy", r8, 1'b1);
    check("bp_release_valid", ov8, 1'b0);
    @(negedge clk);
    check("bp_no_new_op", r8, 1'b1);

    // Reset mid-RUN
    a8 = 8'd1; b8 = 8'd7; s8 = 1'b1; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    @(negedge clk);
    check("midrun_state", st8, RUN);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_res", res8, 8'h00);
    check("midrst_valid", ov8, 1'b0);
    check("midrst_rdy", r8, 1'b1);
    check("midrst_flags", {c8, o8, z8}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_rdy", r8, 1'b1);
    check("postrst_valid", ov8, 1'b0);
    do8(8'd1, 8'd7, 1'b1, 8'hFA, 1'b0, 1'b0, 1'b0);
    do8(8'h7F, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

endmodule
